lsu_dmem_port: RTL and testbench
================================

# lsu_dmem_port

Load/store initiator between the RISC-V execute stage and the word-addressed data memory `dmem`. Takes one byte-addressed load or store at a time with RV32I width encoding (`funct3`). Drives `dmem`'s word address, write data and write enable. Returns sign- or zero-extended load data and a completion or error response. Sub-word stores are done as read-modify-write, because `dmem` only writes whole words.

## Interface
- `DATA_WIDTH`, 32, data and address width
- `MEM_WORDS`, 2048, `dmem` depth in words; word index ≥ `MEM_WORDS` is out of range
- `clk` in 1 — single clock; `dmem` writes on the same rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `req_valid` in 1 — request present
- `req_ready` out 1 — request accepted on a rising edge where `req_valid & req_ready`
- `req_store` in 1 — 1 = store, 0 = load
- `req_funct3` in 3 — 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only)
- `req_addr` in 32 — byte address
- `req_wdata` in 32 — store data; low byte/half used for SB/SH
- `rsp_valid` out 1 — one-cycle completion pulse
- `rsp_rdata` out 32 — extended load data; 0 for stores and errors
- `rsp_err` out 1 — qualified by `rsp_valid`
- `mem_addr` out 32 — word index = `req_addr[31:2]`
- `mem_write_data` out 32
- `mem_write_en` out 1
- `mem_read_data` in 32 — combinational read of `mem_addr`; reads as 0 while `mem_write_en` is high

## Operation
- FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- `req_ready` = (state == IDLE).
- On accept, latch `addr`, `funct3`, `store` and `wdata`, then check for errors.
- Error conditions:
  - `funct3` in {011, 110, 111}
  - store with `funct3` in {100, 101}
  - H/HU with `addr[0]` ≠ 0
  - W with `addr[1:0]` ≠ 0
  - `addr[31:2]` ≥ `MEM_WORDS`
- On error: go to RESP with `rsp_err` = 1 and `rsp_rdata` = 0. No memory access is made.
- Transitions with no error:
  - load → LOAD
  - SW → STORE
  - SB/SH → RMW_RD
- LOAD: drive `mem_addr`, `mem_write_en` = 0, and capture the extracted lane at the clock edge.
  - Lane select: byte `addr[1:0]`, half `addr[1]`.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Next state: RESP.
- STORE: drive `mem_addr`, `mem_write_data` = `wdata`, `mem_write_en` = 1. Next state: RESP.
- RMW_RD: drive `mem_addr` with `mem_write_en` = 0 and capture `mem_read_data` into the merge register. Next state: RMW_WR.
- RMW_WR: drive the merged word with `mem_write_en` = 1.
  - SB replaces byte `addr[1:0]` with `wdata[7:0]`.
  - SH replaces half `addr[1]` with `wdata[15:0]`.
  - Next state: RESP.
- RESP: `rsp_valid` = 1 for exactly one cycle, then IDLE.
- In IDLE, RESP and error paths: `mem_addr` = 0, `mem_write_data` = 0, `mem_write_en` = 0.
- `mem_write_en` is high only in STORE or RMW_WR, for exactly one cycle per store.

## Timing
- Request accepted at edge E0. Latency to the `rsp_valid` cycle:
  - Error: RESP during E0–E1
  - Load / SW: memory cycle during E0–E1, RESP during E1–E2
  - SB / SH: RMW_RD during E0–E1, RMW_WR during E1–E2 (word written at E2), RESP during E2–E3
- Next accept is possible at the edge ending the first IDLE cycle after RESP. One outstanding request maximum.
- `rsp_rdata` and `rsp_err` are registered and held stable through RESP. Both are 0 outside RESP.
- `req_*` inputs are ignored when not accepted. Changes to `req_*` after accept have no effect.
- Reset values while `rst_n` is low, taking effect asynchronously:
  - state IDLE, `req_ready` 1
  - `rsp_valid`, `rsp_rdata`, `rsp_err` = 0
  - `mem_addr`, `mem_write_data`, `mem_write_en` = 0
- Reset during RMW_RD or RMW_WR before the write edge: no write occurs and no response is issued.

## Test plan
- SW `req_wdata`=0xDEADBEEF @0x10, then LW @0x10:
  - `mem_addr`=4 with `mem_write_en` pulsed for one cycle
  - LW returns `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, `rsp_valid` two cycles after accept
- SB 0xAA @0x11 over 0xDEADBEEF:
  - word becomes 0xDEADAAEF, `rsp_valid` three cycles after accept
  - LB @0x11 → 0xFFFFFFAA; LBU @0x11 → 0x000000AA
- SH 0x8001 @0x12:
  - word becomes 0x8001AAEF
  - LH @0x12 → 0xFFFF8001; LHU → 0x00008001; LH @0x10 → 0xFFFFAAEF
- Errors: LW @0x13, SH @0x11, `funct3`=011, SB with `funct3`=100, LW @0x2000
  - each gives `rsp_err`=1 and `rsp_rdata`=0 in the cycle after accept
  - `mem_write_en` never asserts; memory unchanged
- Back-to-back `req_valid` held high with SB, LW, SW:
  - `req_ready` low from the accepting edge until RESP completes
  - each request accepted exactly once, in order
- Reset pulse during RMW_RD of SB @0x11:
  - word unchanged, no `rsp_valid`
  - all outputs 0 and `req_ready` = 1 while `rst_n` is low; next LW works normally

Source files
------------

// File: rtl/lsu_dmem_port_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_dmem_port_if
// Description : Bundle of the execute-side request/response handshake and the
//               word-addressed data-memory bus served by lsu_dmem_port.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_dmem_port_if #(
    parameter int DATA_WIDTH = 32
);
    // Request from the execute stage
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic [2:0]            req_funct3;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    // Completion back to the execute stage
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    // Word-addressed data memory
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_write_en;
    logic [DATA_WIDTH-1:0] mem_read_data;

    // The load/store unit side
    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_write_data, mem_write_en
    );

    // The execute stage plus memory side
    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_write_data, mem_write_en
    );
endinterface
`default_nettype wire

// File: rtl/lsu_dmem_port.sv
`default_nettype none
// ============================================================================
// Module      : lsu_dmem_port
// Description : Single-outstanding load/store initiator for a word-addressed
//               data memory. Sub-word stores use read-modify-write; loads are
//               lane-extracted and sign/zero extended.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_dmem_port #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 2048
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    lsu_dmem_port_if.slave   bus
);

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;
    localparam logic [DATA_WIDTH-3:0] c_mem_words = (DATA_WIDTH-2)'(MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [2:0]            r_funct3;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_merge;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    logic                  w_req_err;
    logic [7:0]            w_rd_byte;
    logic [15:0]           w_rd_half;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [4:0]            w_byte_shift;
    logic [4:0]            w_half_shift;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_mem_active;

    // Classify the incoming request as illegal (bad encoding, misaligned, out of range)
    always_comb begin
        w_req_err = 1'b0;
        case (bus.req_funct3)
            c_f3_b:  w_req_err = 1'b0;
            c_f3_h:  w_req_err = bus.req_addr[0];
            c_f3_w:  w_req_err = (bus.req_addr[1:0] != 2'b00);
            c_f3_bu: w_req_err = bus.req_store;
            c_f3_hu: w_req_err = bus.req_store | bus.req_addr[0];
            default: w_req_err = 1'b1;
        endcase
        if (bus.req_addr[DATA_WIDTH-1:2] >= c_mem_words) begin
            w_req_err = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; stores of a full word skip the read phase
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (w_req_err)                     w_state_next = RESP;
                    else if (!bus.req_store)           w_state_next = LOAD;
                    else if (bus.req_funct3 == c_f3_w) w_state_next = STORE;
                    else                               w_state_next = RMW_RD;
                end
            end
            LOAD, STORE, RMW_WR: w_state_next = RESP;
            RMW_RD:              w_state_next = RMW_WR;
            RESP:                w_state_next = IDLE;
            default:             w_state_next = IDLE;
        endcase
    end

    // Pick the addressed byte and half out of the memory read word
    always_comb begin
        w_rd_byte = bus.mem_read_data[7:0];
        w_rd_half = r_addr[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
        case (r_addr[1:0])
            2'b00:   w_rd_byte = bus.mem_read_data[7:0];
            2'b01:   w_rd_byte = bus.mem_read_data[15:8];
            2'b10:   w_rd_byte = bus.mem_read_data[23:16];
            default: w_rd_byte = bus.mem_read_data[31:24];
        endcase
    end

    // Extend the selected lane according to the load width
    always_comb begin
        w_load_data = '0;
        case (r_funct3)
            c_f3_b:  w_load_data = {{(DATA_WIDTH-8){w_rd_byte[7]}}, w_rd_byte};
            c_f3_h:  w_load_data = {{(DATA_WIDTH-16){w_rd_half[15]}}, w_rd_half};
            c_f3_w:  w_load_data = bus.mem_read_data;
            c_f3_bu: w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_rd_byte};
            c_f3_hu: w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_rd_half};
            default: w_load_data = '0;
        endcase
    end

    // Merge store data into the previously read word for SB/SH
    always_comb begin
        w_byte_shift = {r_addr[1:0], 3'b000};
        w_half_shift = {r_addr[1], 4'b0000};
        if (r_funct3 == c_f3_b) begin
            w_merged = (r_merge & ~(DATA_WIDTH'(8'hFF) << w_byte_shift))
                     | (DATA_WIDTH'(r_wdata[7:0]) << w_byte_shift);
        end else begin
            w_merged = (r_merge & ~(DATA_WIDTH'(16'hFFFF) << w_half_shift))
                     | (DATA_WIDTH'(r_wdata[15:0]) << w_half_shift);
        end
    end

    // Request capture, read-data capture and the registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_funct3    <= '0;
            r_wdata     <= '0;
            r_merge     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_addr      <= bus.req_addr;
                        r_funct3    <= bus.req_funct3;
                        r_wdata     <= bus.req_wdata;
                        r_rsp_err   <= w_req_err;
                        r_rsp_rdata <= '0;
                    end
                end
                LOAD:    r_rsp_rdata <= w_load_data;
                RMW_RD:  r_merge     <= bus.mem_read_data;
                RESP: begin
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign w_mem_active = (r_state == LOAD) || (r_state == STORE) ||
                          (r_state == RMW_RD) || (r_state == RMW_WR);

    assign bus.req_ready      = (r_state == IDLE);
    assign bus.rsp_valid      = (r_state == RESP);
    assign bus.rsp_rdata      = r_rsp_rdata;
    assign bus.rsp_err        = r_rsp_err;
    assign bus.mem_addr       = w_mem_active ? {2'b00, r_addr[DATA_WIDTH-1:2]} : '0;
    assign bus.mem_write_en   = (r_state == STORE) || (r_state == RMW_WR);
    assign bus.mem_write_data = (r_state == STORE)  ? r_wdata  :
                                (r_state == RMW_WR) ? w_merged : '0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_dmem_port
// Description : Scoreboard bench for lsu_dmem_port with a word-array memory,
//               directed scenarios and randomized load/store traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_dmem_port;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   outstanding = 0;

    logic [31:0] dmem    [0:2047];
    logic [31:0] ref_mem [0:2047];
    exp_t        exp_q [$];
    wr_t         wr_q  [$];

    lsu_dmem_port_if #(.DATA_WIDTH(32)) bus ();

    lsu_dmem_port #(.DATA_WIDTH(32), .MEM_WORDS(2048)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    // Memory: writes at the clock edge, combinational read, zero while writing
    always @(posedge clk) begin
        if (bus.mem_write_en && bus.mem_addr < 32'd2048)
            dmem[bus.mem_addr[10:0]] = bus.mem_write_data;
    end
    assign bus.mem_read_data = bus.mem_write_en ? 32'h0 :
                               ((bus.mem_addr < 32'd2048) ? dmem[bus.mem_addr[10:0]] : 32'h0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour computed straight from the load/store rules
    task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic err, output int lat);
        int unsigned idx;
        int unsigned off;
        logic [31:0] word;
        logic [31:0] sh;
        logic [31:0] nw;
        idx = a / 4;
        off = a % 4;
        err = (f3 == 3 || f3 == 6 || f3 == 7) || (st && (f3 == 4 || f3 == 5)) ||
              ((f3 == 1 || f3 == 5) && (a % 2 != 0)) || (f3 == 2 && off != 0) ||
              (idx >= 2048);
        rd  = 32'h0;
        lat = 0;
        if (err) return;
        word = ref_mem[idx];
        sh   = word >> (8 * off);
        if (!st) begin
            lat = 1;
            case (f3)
                3'd0: rd = sh[7]  ? (32'hFFFFFF00 | (sh & 32'hFF))   : (sh & 32'hFF);
                3'd1: rd = sh[15] ? (32'hFFFF0000 | (sh & 32'hFFFF)) : (sh & 32'hFFFF);
                3'd2: rd = word;
                3'd4: rd = sh & 32'hFF;
                default: rd = sh & 32'hFFFF;
            endcase
        end else begin
            if (f3 == 2) begin
                lat = 1;
                nw  = wd;
            end else if (f3 == 0) begin
                lat = 2;
                nw  = (word & ~(32'hFF << (8 * off))) | ((wd & 32'hFF) << (8 * off));
            end else begin
                lat = 2;
                nw  = (word & ~(32'hFFFF << (8 * off))) | ((wd & 32'hFFFF) << (8 * off));
            end
            ref_mem[idx] = nw;
            wr_q.push_back('{addr: idx, data: nw});
        end
    endtask

    // Present a request, wait (bounded) for acceptance, log the expectation
    task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold, input bit expect_rsp);
        int   waited = 0;
        exp_t e;
        int   lat;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        if (expect_rsp) begin
            model(st, f3, a, wd, e.rdata, e.err, lat);
            e.cyc = cyc + 1 + lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (expect_rsp) outstanding = 1'b1;
        #1;
        bus.req_valid  = hold;
        bus.req_store  = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
        check({tag, "_rsp_err"}, {31'd0, bus.rsp_err}, 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_write_data, 32'd0);
        check({tag, "_mem_we"}, {31'd0, bus.mem_write_en}, 32'd0);
    endtask

    // Monitor: responses, idle response values, busy handshake, memory writes
    always @(negedge clk) begin : monitor
        exp_t e;
        wr_t  w;
        if (rst_n) begin
            if (outstanding) check("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_cycle", cyc, e.cyc);
                    check("rsp_rdata", bus.rsp_rdata, e.rdata);
                    check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
                end
                outstanding = 1'b0;
            end else begin
                check("idle_rsp_rdata", bus.rsp_rdata, 32'd0);
                check("idle_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
            end
            if (bus.mem_write_en) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", bus.mem_addr, 32'hFFFFFFFF);
                end else begin
                    w = wr_q.pop_front();
                    check("write_addr", bus.mem_addr, w.addr);
                    check("write_data", bus.mem_write_data, w.data);
                end
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        for (int i = 0; i < 2048; i++) begin
            dmem[i]    = $urandom;
            ref_mem[i] = dmem[i];
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Word store/load, then sub-word read-modify-write and extensions
        do_req(1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 1);
        do_req(0, 3'd2, 32'h10, 32'h0, 0, 1);
        do_req(1, 3'd0, 32'h11, 32'h000000AA, 0, 1);
        do_req(0, 3'd0, 32'h11, 32'h0, 0, 1);
        do_req(0, 3'd4, 32'h11, 32'h0, 0, 1);
        wait_idle();
        check("dmem_after_sb", dmem[4], 32'hDEADAAEF);
        do_req(1, 3'd1, 32'h12, 32'h00008001, 0, 1);
        do_req(0, 3'd1, 32'h12, 32'h0, 0, 1);
        do_req(0, 3'd5, 32'h12, 32'h0, 0, 1);
        do_req(0, 3'd1, 32'h10, 32'h0, 0, 1);
        wait_idle();
        check("dmem_after_sh", dmem[4], 32'h8001AAEF);

        // Error cases: none may touch memory
        do_req(0, 3'd2, 32'h13, 32'h0, 0, 1);
        do_req(1, 3'd1, 32'h11, 32'h1234, 0, 1);
        do_req(0, 3'd3, 32'h10, 32'h0, 0, 1);
        do_req(1, 3'd4, 32'h10, 32'h55, 0, 1);
        do_req(0, 3'd2, 32'h2000, 32'h0, 0, 1);
        wait_idle();
        check("dmem_after_errors", dmem[4], 32'h8001AAEF);

        // Back-to-back with req_valid held high
        do_req(1, 3'd0, 32'h21, 32'h00000055, 1, 1);
        do_req(0, 3'd2, 32'h20, 32'h0, 1, 1);
        do_req(1, 3'd2, 32'h24, 32'h12345678, 0, 1);
        wait_idle();

        // Reset while an SB is in its read phase
        do_req(1, 3'd0, 32'h11, 32'h000000CC, 0, 0);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        check_reset_outputs("midreset_hold");
        rst_n = 1'b1;
        check("dmem_after_reset", dmem[4], 32'h8001AAEF);
        do_req(0, 3'd2, 32'h10, 32'h0, 0, 1);
        wait_idle();

        // Randomized traffic over a small window plus occasional out-of-range
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) a = a | ($urandom & 32'hFFFFE000) | 32'h2000;
            do_req(1'($urandom), 3'($urandom), a, $urandom, 1'($urandom), 1);
            if ($urandom_range(0, 3) == 0) begin
                bus.req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        bus.req_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 16; i++) check("final_mem", dmem[i], ref_mem[i]);
        check("pending_writes", wr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
